// File: rtl/spi_shift_pkg.sv
// rtl/spi_shift_pkg.sv - shared types and constants for the SPI master serial data path
package spi_shift_pkg;

   // Default transfer word width in bits
   localparam int SPI_DATA_W = 8;

   // Shifter control states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      SHIFT  = 2'd2
   } spi_state_e;

endpackage

// File: rtl/spi_strobe_sel.sv
// rtl/spi_strobe_sel.sv - cpol/cpha selection of the baud generator's send/receive strobe pair
module spi_strobe_sel (
   input  logic cpol_i,
   input  logic cpha_i,
   input  logic send_sclk_i,
   input  logic send_sclk0_i,
   input  logic recv_sclk_i,
   input  logic recv_sclk0_i,
   output logic tx_stb_o,
   output logic rx_stb_o
);

   // Modes 0 and 3 share one strobe pair; modes 1 and 2 use the *sclk0 pair
   logic use_sclk;

   assign use_sclk = (cpol_i == cpha_i);
   assign tx_stb_o = use_sclk ? send_sclk_i : send_sclk0_i;
   assign rx_stb_o = use_sclk ? recv_sclk_i : recv_sclk0_i;

endmodule

// File: rtl/spi_shifter.sv
// rtl/spi_shifter.sv - SPI master word shifter (MOSI drive, MISO capture); option macro SPI_SHIFT_LSBFE_EN
module spi_shifter
   import spi_shift_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              ss_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic              lsbfe_i,
   input  logic              send_data_i,
   input  logic [DATA_W-1:0] data_mosi_i,
   input  logic              miso_i,
   input  logic              mosi_send_sclk_i,
   input  logic              mosi_send_sclk0_i,
   input  logic              miso_recieve_sclk_i,
   input  logic              miso_recieve_sclk0_i,
   output logic              mosi_o,
   output logic [DATA_W-1:0] data_miso_o,
   output logic              receive_data_o,
   output logic              tx_busy_o
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam int IW = $clog2(DATA_W);

   spi_state_e        state_q, state_d;
   logic [DATA_W-1:0] tx_reg_q, tx_reg_d;
   logic [DATA_W-1:0] rx_reg_q, rx_reg_d;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
   logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
   logic              mosi_q, mosi_d;
   logic [DATA_W-1:0] data_miso_q, data_miso_d;
   logic              rcv_q, rcv_d;
   logic              tx_stb, rx_stb;
   logic [IW-1:0]     tx_idx, rx_idx;

   spi_strobe_sel u_strobe_sel (
      .cpol_i       (cpol_i),
      .cpha_i       (cpha_i),
      .send_sclk_i  (mosi_send_sclk_i),
      .send_sclk0_i (mosi_send_sclk0_i),
      .recv_sclk_i  (miso_recieve_sclk_i),
      .recv_sclk0_i (miso_recieve_sclk0_i),
      .tx_stb_o     (tx_stb),
      .rx_stb_o     (rx_stb)
   );

   // Counters index only while below DATA_W, so the low IW bits address the word
`ifdef SPI_SHIFT_LSBFE_EN
   logic lsb_q, lsb_d;

   assign tx_idx = lsb_q ? tx_cnt_q[IW-1:0] : (IW'(DATA_W - 1) - tx_cnt_q[IW-1:0]);
   assign rx_idx = lsb_q ? rx_cnt_q[IW-1:0] : (IW'(DATA_W - 1) - rx_cnt_q[IW-1:0]);
`else
   logic unused_lsbfe;

   assign unused_lsbfe = lsbfe_i;
   assign tx_idx = IW'(DATA_W - 1) - tx_cnt_q[IW-1:0];
   assign rx_idx = IW'(DATA_W - 1) - rx_cnt_q[IW-1:0];
`endif

   // State register and datapath registers, asynchronously cleared
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q     <= IDLE;
         tx_reg_q    <= '0;
         rx_reg_q    <= '0;
         tx_cnt_q    <= '0;
         rx_cnt_q    <= '0;
         mosi_q      <= 1'b0;
         data_miso_q <= '0;
         rcv_q       <= 1'b0;
`ifdef SPI_SHIFT_LSBFE_EN
         lsb_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tx_reg_q    <= tx_reg_d;
         rx_reg_q    <= rx_reg_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         mosi_q      <= mosi_d;
         data_miso_q <= data_miso_d;
         rcv_q       <= rcv_d;
`ifdef SPI_SHIFT_LSBFE_EN
         lsb_q       <= lsb_d;
`endif
      end
   end

   // Next-state logic: load, shift on strobes, complete on last receive strobe, abort on ss high
   always_comb begin
      state_d     = state_q;
      tx_reg_d    = tx_reg_q;
      rx_reg_d    = rx_reg_q;
      tx_cnt_d    = tx_cnt_q;
      rx_cnt_d    = rx_cnt_q;
      mosi_d      = mosi_q;
      data_miso_d = data_miso_q;
      rcv_d       = 1'b0;
`ifdef SPI_SHIFT_LSBFE_EN
      lsb_d       = lsb_q;
`endif
      case (state_q)
         IDLE: begin
            if (send_data_i && !ss_i) begin
               tx_reg_d = data_mosi_i;
`ifdef SPI_SHIFT_LSBFE_EN
               lsb_d    = lsbfe_i;
`endif
               tx_cnt_d = '0;
               rx_cnt_d = '0;
               state_d  = LOADED;
            end
         end
         LOADED: begin
            if (ss_i) begin
               state_d  = IDLE;
               tx_cnt_d = '0;
               rx_cnt_d = '0;
               mosi_d   = 1'b0;
            end else if (tx_stb) begin
               mosi_d   = tx_reg_q[tx_idx];
               tx_cnt_d = CW'(1);
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (ss_i) begin
               state_d  = IDLE;
               tx_cnt_d = '0;
               rx_cnt_d = '0;
               mosi_d   = 1'b0;
            end else begin
               if (tx_stb && (tx_cnt_q < CW'(DATA_W))) begin
                  mosi_d   = tx_reg_q[tx_idx];
                  tx_cnt_d = tx_cnt_q + CW'(1);
               end
               if (rx_stb) begin
                  rx_reg_d[rx_idx] = miso_i;
                  rx_cnt_d         = rx_cnt_q + CW'(1);
                  if (rx_cnt_q == CW'(DATA_W - 1)) begin
                     data_miso_d = rx_reg_d;
                     rcv_d       = 1'b1;
                     state_d     = IDLE;
                     tx_cnt_d    = '0;
                     rx_cnt_d    = '0;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mosi_o         = mosi_q;
   assign data_miso_o    = data_miso_q;
   assign receive_data_o = rcv_q;
   assign tx_busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_shifter.sv
// tb/tb_spi_shifter.sv - self-checking scoreboard bench for spi_shifter
module tb_spi_shifter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ss = 1'b1;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic       lsbfe = 1'b0;
   logic       send = 1'b0;
   logic [7:0] data_mosi = 8'h00;
   logic       miso = 1'b0;
   logic       s_sclk = 1'b0;
   logic       s_sclk0 = 1'b0;
   logic       r_sclk = 1'b0;
   logic       r_sclk0 = 1'b0;
   logic       mosi_o;
   logic [7:0] data_miso_o;
   logic       receive_data_o;
   logic       tx_busy_o;

   int         n_tests = 0;
   int         n_fail = 0;
   int         rcv_pulses = 0;
   int         n_pushed = 0;
   logic [7:0] exp_q[$];

   spi_shifter #(.DATA_W(8)) dut (
      .PCLK                 (clk),
      .PRESET               (rst),
      .ss_i                 (ss),
      .cpol_i               (cpol),
      .cpha_i               (cpha),
      .lsbfe_i              (lsbfe),
      .send_data_i          (send),
      .data_mosi_i          (data_mosi),
      .miso_i               (miso),
      .mosi_send_sclk_i     (s_sclk),
      .mosi_send_sclk0_i    (s_sclk0),
      .miso_recieve_sclk_i  (r_sclk),
      .miso_recieve_sclk0_i (r_sclk0),
      .mosi_o               (mosi_o),
      .data_miso_o          (data_miso_o),
      .receive_data_o       (receive_data_o),
      .tx_busy_o            (tx_busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Completion monitor: every receive pulse must match the oldest queued word
   always @(negedge clk) begin
      if (receive_data_o) begin
         rcv_pulses++;
         if (exp_q.size() == 0) begin
            check("rx_unexpected", 32'd1, 32'd0);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("rx_word", {24'd0, data_miso_o}, {24'd0, e});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_stb(input bit alt, input bit tx, input bit rx, input bit noise);
      if (alt) begin
         s_sclk0 = tx; r_sclk0 = rx; s_sclk = noise; r_sclk = noise;
      end else begin
         s_sclk = tx; r_sclk = rx; s_sclk0 = noise; r_sclk0 = noise;
      end
   endtask

   task automatic load(input logic [7:0] tx, input bit push, input logic [7:0] rx);
      if (push) begin
         exp_q.push_back(rx);
         n_pushed++;
      end
      send = 1'b1;
      data_mosi = tx;
      tick();
      send = 1'b0;
      check("busy_after_load", {31'd0, tx_busy_o}, 32'd1);
      check("rcv_after_load", {31'd0, receive_data_o}, 32'd0);
   endtask

   task automatic xfer(input logic [7:0] tx, input logic [7:0] rx, input bit lsb, input bit alt,
                       input bit noise, input int stop_after, input int inject_at);
      for (int k = 0; k < 8; k++) begin
         int idx;
         if (k == stop_after) break;
         idx = lsb ? k : 7 - k;
         if (k == inject_at) begin
            send = 1'b1;
            data_mosi = 8'hFF;
         end
         set_stb(alt, 1'b1, 1'b0, noise);
         tick();
         set_stb(alt, 1'b0, 1'b0, 1'b0);
         send = 1'b0;
         check($sformatf("mosi_b%0d", k), {31'd0, mosi_o}, {31'd0, tx[idx]});
         if (noise) begin
            set_stb(alt, 1'b0, 1'b0, 1'b1);
            miso = ~rx[idx];
            tick();
            set_stb(alt, 1'b0, 1'b0, 1'b0);
         end
         miso = rx[idx];
         set_stb(alt, 1'b0, 1'b1, noise);
         tick();
         set_stb(alt, 1'b0, 1'b0, 1'b0);
         if (k < 7) check($sformatf("busy_b%0d", k), {31'd0, tx_busy_o}, 32'd1);
      end
      if (stop_after < 0) begin
         check("rcv_at_end", {31'd0, receive_data_o}, 32'd1);
         check("busy_at_end", {31'd0, tx_busy_o}, 32'd0);
      end
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_mosi", {31'd0, mosi_o}, 32'd0);
      check("rst_data", {24'd0, data_miso_o}, 32'd0);
      check("rst_rcv", {31'd0, receive_data_o}, 32'd0);
      check("rst_busy", {31'd0, tx_busy_o}, 32'd0);

      // load dropped while slave select is high
      send = 1'b1;
      data_mosi = 8'h11;
      tick();
      send = 1'b0;
      check("ss_high_drop", {31'd0, tx_busy_o}, 32'd0);
      ss = 1'b0;

      // mode 0, MSB first
      load(8'hA5, 1'b1, 8'h3C);
      xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, -1, -1);
      tick();
      check("single_pulse", {31'd0, receive_data_o}, 32'd0);
      check("data_hold", {24'd0, data_miso_o}, 32'h3C);

      // abort after four receive strobes
      load(8'h5A, 1'b0, 8'h00);
      xfer(8'h5A, 8'hF0, 1'b0, 1'b0, 1'b0, 4, -1);
      ss = 1'b1;
      tick();
      check("abort_busy", {31'd0, tx_busy_o}, 32'd0);
      check("abort_mosi", {31'd0, mosi_o}, 32'd0);
      check("abort_data", {24'd0, data_miso_o}, 32'h3C);
      tick();
      check("abort_no_rcv", {31'd0, receive_data_o}, 32'd0);
      ss = 1'b0;

      // mode 1 on the sclk0 pair with the other pair toggling as noise
      cpha = 1'b1;
      load(8'h5A, 1'b1, 8'hC3);
      xfer(8'h5A, 8'hC3, 1'b0, 1'b1, 1'b1, -1, -1);
      tick();
      cpha = 1'b0;

      // mid-transfer load ignored, then back-to-back load on the completion cycle
      load(8'h00, 1'b1, 8'h66);
      xfer(8'h00, 8'h66, 1'b0, 1'b0, 1'b0, -1, 3);
      load(8'h81, 1'b1, 8'h7E);
      xfer(8'h81, 8'h7E, 1'b0, 1'b0, 1'b0, -1, -1);
      tick();

      // asynchronous reset in SHIFT
      load(8'hFF, 1'b0, 8'h00);
      xfer(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 3, -1);
      check("pre_rst_mosi", {31'd0, mosi_o}, 32'd1);
      rst = 1'b1;
      #1;
      check("arst_mosi", {31'd0, mosi_o}, 32'd0);
      check("arst_busy", {31'd0, tx_busy_o}, 32'd0);
      check("arst_data", {24'd0, data_miso_o}, 32'd0);
      check("arst_rcv", {31'd0, receive_data_o}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      load(8'h96, 1'b1, 8'h69);
      xfer(8'h96, 8'h69, 1'b0, 1'b0, 1'b0, -1, -1);
      tick();

`ifdef SPI_SHIFT_LSBFE_EN
      lsbfe = 1'b1;
      load(8'h01, 1'b1, 8'h80);
      lsbfe = 1'b0;
      xfer(8'h01, 8'h80, 1'b1, 1'b0, 1'b0, -1, -1);
      tick();
`endif

      tick();
      check("queue_drained", exp_q.size(), 32'd0);
      check("pulse_count", rcv_pulses, n_pushed);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_shifter.md
# spi_shifter

Serial data path of the APB-SPI master, directly downstream of the baud generator. Consumes that block's one-cycle send/receive strobes to drive MOSI and sample MISO, one word per transfer. Loads the transmit word from the APB register side and returns the received word with a one-cycle completion pulse.

## Interface
- DATA_W, 8, transfer word width in bits (≥2)
- PCLK  in  1  system clock, all logic rising-edge
- PRESET  in  1  reset, asynchronous, active-high
- ss_i  in  1  slave select, active-low; high aborts/holds idle
- cpol_i, cpha_i  in  1 each  clock polarity/phase, select strobe pair
- lsbfe_i  in  1  1 = LSB first (see Configuration)
- send_data_i  in  1  load request, one-cycle pulse
- data_mosi_i  in  DATA_W  word to transmit
- miso_i  in  1  serial input, pre-synchronised
- mosi_send_sclk_i, mosi_send_sclk0_i  in  1 each  send strobes, mode 0/3 and mode 1/2
- miso_recieve_sclk_i, miso_recieve_sclk0_i  in  1 each  receive strobes, mode 0/3 and mode 1/2
- mosi_o  out  1  serial output
- data_miso_o  out  DATA_W  last completed received word
- receive_data_o  out  1  one-cycle pulse, data_miso_o updated
- tx_busy_o  out  1  high in LOADED or SHIFT

## Operation
- Strobe select: cpol_i==cpha_i → tx_stb=mosi_send_sclk_i, rx_stb=miso_recieve_sclk_i; else the *sclk0_i pair.
- States IDLE, LOADED, SHIFT.
- IDLE: send_data_i=1 and ss_i=0 → tx_reg<=data_mosi_i, latch bit order, tx_cnt=rx_cnt=0, → LOADED. send_data_i with ss_i=1 is dropped.
- LOADED: tx_stb → mosi_o<=bit 0 of order, tx_cnt=1, → SHIFT. rx_stb ignored.
- SHIFT: tx_stb with tx_cnt<DATA_W → mosi_o<=bit tx_cnt, tx_cnt++; tx_stb with tx_cnt==DATA_W ignored (mosi_o holds). rx_stb → rx_reg[bit rx_cnt]<=miso_i, rx_cnt++.
- On DATA_W-th rx_stb: data_miso_o<=completed word (including this bit), receive_data_o=1 next cycle, → IDLE.
- MSB-first: bit k = index DATA_W-1-k for both tx and rx. LSB-first: index k.
- tx_stb and rx_stb in the same cycle: both act, tx first in bit order (rx uses pre-increment rx_cnt).
- send_data_i while tx_busy_o=1: ignored, tx_reg unchanged.
- ss_i=1 in LOADED/SHIFT: abort → IDLE next cycle, counters cleared, mosi_o<=0, no receive_data_o, data_miso_o unchanged.
- Counters width $clog2(DATA_W+1); never wrap.

## Timing
- Reset: state IDLE, mosi_o 0, data_miso_o 0, receive_data_o 0, tx_busy_o 0, tx_reg/rx_reg 0.
- Strobe → mosi_o/rx_reg update: 1 PCLK (registered).
- tx_busy_o rises the cycle after an accepted send_data_i; falls with receive_data_o.
- receive_data_o high exactly 1 cycle, coincident with new data_miso_o.
- New send_data_i accepted on the cycle receive_data_o is high (state already IDLE).
- Reset mid-transfer: immediate return to reset values, asynchronous.

## Configuration
- SPI_SHIFT_LSBFE_EN defined: lsbfe_i latched at load, selects bit order per transfer.
- Undefined: MSB-first only, lsbfe_i unused, order latch and index mux omitted.

## Structure
- Package spi_shift_pkg: state enum (IDLE, LOADED, SHIFT), DATA_W default constant.
- Sub-module spi_strobe_sel: combinational cpol/cpha strobe mux, reusable by the slave-side path.

## Test plan
- Mode 0, MSB-first, data_mosi_i=0xA5, miso_i replays 0x3C → mosi_o sequence 1,0,1,0,0,1,0,1 on successive tx strobes; data_miso_o=0x3C with single receive_data_o pulse.
- Mode 1 (cpha=1,cpol=0) strobes only on *sclk0_i; *sclk_i toggled as noise → transfer completes identically, noise ignored.
- LSBFE_EN build, lsbfe_i=1, data 0x01 → mosi_o first bit 1 then seven 0; miso 0x80 pattern LSB-first → data_miso_o=0x80.
- ss_i raised after 4 rx strobes → tx_busy_o falls next cycle, no receive_data_o, data_miso_o keeps prior 0x3C.
- send_data_i=0xFF pulsed mid-transfer of 0x00 → mosi_o stays 0 all 8 bits; following load after receive_data_o accepted.
- PRESET asserted mid-SHIFT → all outputs 0 immediately; next load transfers cleanly.
